button_matrix_scanner: RTL and testbench

//  Input-side counterpart of the LED array driver. Scans an NxN push-button matrix one column at a time
//  and samples the active-low row returns. Debounces every key and publishes the pressed-key map in the

---
 rtl/conway_pkg.sv | 12 +
 rtl/button_matrix_scanner_key_debouncer.sv | 52 +++++
 rtl/button_matrix_scanner.sv | 124 ++++++++++++
 tb/tb_button_matrix_scanner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared types for the Conway board: cell grid and the button matrix that edits it.
package conway_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE
   } scan_state_t;

   localparam int MAX_MATRIX_N = 8;

endpackage

// File: rtl/button_matrix_scanner_key_debouncer.sv
// Per-key debouncer: flips the held state after DEBOUNCE_SCANS consecutive
// differing samples and pulses rise on a press.
module key_debouncer #(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic raw,
   output logic pressed,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pressed_q, pressed_d;
   logic          rise_q, rise_d;

   always_comb begin
      cnt_d     = cnt_q;
      pressed_d = pressed_q;
      rise_d    = 1'b0;
      if (sample_en) begin
         if (raw == pressed_q) begin
            cnt_d = '0;
         end else if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
            cnt_d     = '0;
            pressed_d = raw;
            rise_d    = raw;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         rise_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         rise_q    <= rise_d;
      end
   end

   assign pressed = pressed_q;
   assign rise    = rise_q;

endmodule

// File: rtl/button_matrix_scanner.sv
// NxN push-button matrix scanner: one-hot column drive, synchronized active-low
// row sampling, and a debounced row-major key map (bit r*N+c).
module button_matrix_scanner
   import conway_pkg::*;
#(
   parameter int N              = 8,
   parameter int SETTLE_CYCLES  = 16,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [N-1:0]     rows_in,
   output logic [N-1:0]     cols_out,
   output logic [$clog2(N):0] x,
   output logic [N*N-1:0]   pressed,
   output logic [N*N-1:0]   press_event,
   output logic             frame_done
);

   localparam int XW = $clog2(N) + 1;
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   if (N < 1 || N > MAX_MATRIX_N) begin : g_bad_n
      $error("button_matrix_scanner: N=%0d outside 1..8", N);
   end
   if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("button_matrix_scanner: SETTLE_CYCLES=%0d must be >= 3", SETTLE_CYCLES);
   end
   if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
      $error("button_matrix_scanner: DEBOUNCE_SCANS=%0d must be >= 1", DEBOUNCE_SCANS);
   end

   scan_state_t   state_q, state_d;
   logic [XW-1:0] col_q, col_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic          frame_q, frame_d;
   logic [N-1:0]  rows_s1_q, rows_s2_q;
   logic          sample_now;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      frame_d = 1'b0;
      if (!ena) begin
         state_d = S_IDLE;
         col_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_DRIVE;
               col_d   = '0;
               cnt_d   = '0;
            end
            S_DRIVE: begin
               if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                  state_d = S_SAMPLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SAMPLE: begin
               state_d = S_DRIVE;
               if (col_q == XW'(N - 1)) begin
                  col_d   = '0;
                  frame_d = 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Rows are asynchronous to clk; the settle window covers this two-flop path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         cnt_q     <= '0;
         frame_q   <= 1'b0;
         rows_s1_q <= '0;
         rows_s2_q <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         cnt_q     <= cnt_d;
         frame_q   <= frame_d;
         rows_s1_q <= rows_in;
         rows_s2_q <= rows_s1_q;
      end
   end

   always_comb begin
      cols_out = '0;
      for (int c = 0; c < N; c++) begin
         cols_out[c] = (state_q != S_IDLE) && (col_q == XW'(c));
      end
   end

   assign x          = col_q;
   assign frame_done = frame_q;
   assign sample_now = (state_q == S_SAMPLE) && ena;

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         key_debouncer #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
         ) u_key (
            .clk      (clk),
            .rst_n    (rst_n),
            .sample_en(sample_now && (col_q == XW'(c))),
            .raw      (~rows_s2_q[r]),
            .pressed  (pressed[r*N+c]),
            .rise     (press_event[r*N+c])
         );
      end
   end

endmodule

// File: tb/tb_button_matrix_scanner.sv
// Directed bench for button_matrix_scanner with N=4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3.
module tb_button_matrix_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [3:0]  rows_in;
   logic [3:0]  cols_out;
   logic [2:0]  x;
   logic [15:0] pressed;
   logic [15:0] press_event;
   logic        frame_done;

   logic [15:0] keys;
   int          t;
   int          ph;
   int          n_cmp = 0;
   int          n_bad = 0;

   button_matrix_scanner #(
      .N(4),
      .SETTLE_CYCLES(4),
      .DEBOUNCE_SCANS(3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .rows_in    (rows_in),
      .cols_out   (cols_out),
      .x          (x),
      .pressed    (pressed),
      .press_event(press_event),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Physical matrix: a closed key pulls its row low while its column is driven.
   always_comb begin
      rows_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && cols_out[c]) rows_in[r] = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b0;
      keys  = 16'h0000;
      t     = 0;
      #2;
      chk("rst_cols", cols_out, 0);
      chk("rst_x", x, 0);
      chk("rst_pressed", pressed, 0);
      chk("rst_event", press_event, 0);
      chk("rst_frame", frame_done, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_cols", cols_out, 0);

      // Test 1: empty matrix, two full frames of column stepping
      ena = 1'b1;
      t   = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         ph = (t - 1) % 20;
         chk("t1_cols", cols_out, 32'd1 << (ph / 5));
         chk("t1_x", x, ph / 5);
         chk("t1_frame", frame_done, (t % 20 == 1) && (t > 1));
         chk("t1_pressed", pressed, 0);
      end

      // Test 3: bouncy key r2c1 never reaches three consecutive closed samples
      keys = 16'h0200;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("t3_pressed", pressed, 0);
         chk("t3_event", press_event, 0);
      end
      keys = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t3_pressed", pressed, 0);
      end
      keys = 16'h0200;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("t3_pressed", pressed, 0);
         chk("t3_event", press_event, 0);
      end
      keys = 16'h0000;
      for (int i = 0; i < 20; i++) tick();

      // Test 2: r2c1 and r3c1 held together for three frames
      keys = 16'h2200;
      for (int i = 0; i < 60; i++) begin
         tick();
         chk("t2_pressed", pressed, (t >= 211) ? 32'h2200 : 32'h0);
         chk("t2_event", press_event, (t == 211) ? 32'h2200 : 32'h0);
      end

      // Test 5: drop ena while driving column 2
      while (t < 232) tick();
      chk("t5_col2", cols_out, 4'b0100);
      ena = 1'b0;
      tick();
      chk("t5_cols_off", cols_out, 0);
      chk("t5_x_off", x, 0);
      chk("t5_held", pressed, 32'h2200);
      chk("t5_frame", frame_done, 0);
      chk("t5_event", press_event, 0);
      tick();
      tick();
      chk("t5_cols_idle", cols_out, 0);
      chk("t5_held2", pressed, 32'h2200);
      ena = 1'b1;
      t   = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         ph = (t - 1) % 20;
         chk("t5_cols_restart", cols_out, 32'd1 << (ph / 5));
         chk("t5_x_restart", x, ph / 5);
         chk("t5_pressed", pressed, 32'h2200);
      end

      // Test 4: release both keys; no event on the falling flip
      keys = 16'h0000;
      for (int i = 0; i < 60; i++) begin
         tick();
         chk("t4_pressed", pressed, (t < 71) ? 32'h2200 : 32'h0);
         chk("t4_event", press_event, 0);
      end

      // Test 6: async reset during the column-1 SAMPLE with r2c1 held
      keys = 16'h0200;
      while (t < 150) tick();
      chk("t6_pre_pressed", pressed, 32'h0200);
      chk("t6_pre_cols", cols_out, 4'b0010);
      rst_n = 1'b0;
      #1;
      chk("t6_cols", cols_out, 0);
      chk("t6_x", x, 0);
      chk("t6_pressed", pressed, 0);
      chk("t6_event", press_event, 0);
      chk("t6_frame", frame_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
